// File: rtl/mul_seq.sv
// Unsigned shift-and-add multiplier, BW (4..32) operand width; done/product BW edges after the accepting edge.
// No backpressure: start is taken only in IDLE and ignored while busy or done.
module mul_seq #(
  parameter int BW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [BW-1:0]   a,
  input  logic [BW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*BW-1:0] product
);

  localparam int CW = $clog2(BW);
  localparam logic [CW-1:0] LAST = CW'(BW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     m_q, m_d;
  logic [BW-1:0]     q_q, q_d;
  logic [BW-1:0]     p_q, p_d;
  logic              c_q, c_d;
  logic [CW-1:0]     count_q, count_d;
  logic [2*BW-1:0]   product_q, product_d;
  logic [BW:0]       sum;

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    q_d       = q_q;
    p_d       = p_q;
    c_d       = c_q;
    count_d   = count_q;
    product_d = product_q;
    // The carry is cleared after every shift, so this add never overflows BW+1 bits.
    sum       = {c_q, p_q} + {1'b0, (q_q[0] ? m_q : {BW{1'b0}})};

    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          p_d     = '0;
          c_d     = 1'b0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d = sum[BW:1];
        q_d = {sum[0], q_q[BW-1:1]};
        c_d = 1'b0;
        if (count_q == LAST) begin
          product_d = {sum[BW:1], sum[0], q_q[BW-1:1]};
          state_d   = DONE;
        end else begin
          count_d = count_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      q_q       <= '0;
      p_q       <= '0;
      c_q       <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      q_q       <= q_d;
      p_q       <= p_d;
      c_q       <= c_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq at BW=16: vector table plus ignored-start, reset-abort and back-to-back sequences.
module tb_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        busy;
  logic        done;
  logic [31:0] product;

  int tests;
  int fails;
  logic [31:0] last_prod;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[9];

  mul_seq #(.BW(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a_i),
    .b      (b_i),
    .busy   (busy),
    .done   (done),
    .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One operation from IDLE; ign_at >= 0 pulses start (a=7) at that RUN cycle.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                        input int ign_at, input string name);
    int lat;
    int busy_n;
    int extra;
    @(negedge clk);
    a_i   = a;
    b_i   = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_i   = ~a;
    b_i   = b ^ 16'h5a5a;
    check({name, "_hold"}, {32'd0, product}, {32'd0, last_prod});
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      if (lat == ign_at) begin
        start = 1'b1;
        a_i   = 16'd7;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check({name, "_latency"}, 64'(lat), 64'd16);
    check({name, "_busy_cycles"}, 64'(busy_n), 64'd16);
    check({name, "_product"}, {32'd0, product}, {32'd0, exp});
    check({name, "_busy_in_done"}, {63'd0, busy}, 64'd0);
    @(negedge clk);
    check({name, "_done_drop"}, {63'd0, done}, 64'd0);
    last_prod = exp;
    if (ign_at >= 0) begin
      extra = 0;
      repeat (20) begin
        @(negedge clk);
        if (done || busy) extra++;
      end
      check({name, "_no_second_op"}, 64'(extra), 64'd0);
    end
  endtask

  initial begin
    int t_done[3];
    int nd;
    int cyc;
    int bad;

    tests     = 0;
    fails     = 0;
    last_prod = 32'd0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a_i       = '0;
    b_i       = '0;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
    vecs[3] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[4] = '{16'h1234, 16'h5678, 32'h0626_0060};
    vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
    vecs[6] = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[7] = '{16'h0001, 16'h0001, 32'h0000_0001};
    vecs[8] = '{16'hFFFF, 16'h0000, 32'h0000_0000};

    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_product", {32'd0, product}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p, -1, $sformatf("vec%0d", i));
    end

    run_op(16'd2, 16'd9, 32'h0000_0012, 5, "ignored_start");

    // Back-to-back: start held high, expect a done every 18 cycles.
    @(negedge clk);
    a_i   = 16'h00FF;
    b_i   = 16'h0101;
    start = 1'b1;
    nd    = 0;
    cyc   = 0;
    while (nd < 3 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        t_done[nd] = cyc;
        check($sformatf("b2b_product%0d", nd), {32'd0, product}, 64'h0000_FFFF);
        nd++;
      end
    end
    start = 1'b0;
    check("b2b_pulses", 64'(nd), 64'd3);
    if (nd == 3) begin
      check("b2b_period0", 64'(t_done[1] - t_done[0]), 64'd18);
      check("b2b_period1", 64'(t_done[2] - t_done[1]), 64'd18);
    end
    repeat (20) @(negedge clk);
    last_prod = 32'h0000_FFFF;

    // Reset abort in the middle of RUN.
    a_i   = 16'd3;
    b_i   = 16'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    check("mid_busy_before_rst", {63'd0, busy}, 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_product", {32'd0, product}, 64'd0);
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy || product != 32'd0) bad++;
    end
    check("abort_quiet", 64'(bad), 64'd0);

    // Start presented on the very edge where reset is released.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a_i   = 16'd6;
    b_i   = 16'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_after_rst", {63'd0, busy}, 64'd1);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("after_rst_latency", 64'(cyc), 64'd16);
    check("after_rst_product", {32'd0, product}, 64'h0000_002A);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_seq.md
MUL_SEQ -- requirements
Module: mul_seq

Interface
REQ-001 Parameter: BW, default 16, operand width in bits; legal range 4..32.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 rst_n  input  1  reset; synchronous and active-low.
REQ-004 start  input  1  request a new multiply; sampled only in IDLE.
REQ-005 a  input  BW  multiplicand, unsigned; sampled on the accepting edge.
REQ-006 b  input  BW  multiplier, unsigned; sampled on the accepting edge.
REQ-007 busy  output  1  high while an operation is in progress (RUN).
REQ-008 done  output  1  one-cycle pulse: product has just been updated.
REQ-009 product  output  2*BW  registered unsigned result of the last completed operation.

Function
REQ-010 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-011 In IDLE with start=1 at an edge, the block SHALL load M<=a, Q<=b, P<=0, C<=0 and count<=0, then enter RUN.
REQ-012 In IDLE with start=0, the block SHALL hold all registers.
REQ-013 Each RUN edge SHALL perform one BW-bit add: if Q[0]=1 then {C,P}=P+M (carry-in 0), else {C,P}={0,P}.
REQ-014 On the same edge, {C,P,Q} SHALL be shifted right by one bit, C SHALL be cleared, and count SHALL increment.
REQ-015 After the BW-th RUN edge (count=BW-1 on entry), the block SHALL load product<={P,Q} with the final shifted value and enter DONE.
REQ-016 DONE SHALL last exactly one cycle and then return to IDLE unconditionally.
REQ-017 Latency: for start accepted at edge E0, product and done SHALL be valid after edge E0+BW; done SHALL drop after E0+BW+1.
REQ-018 busy SHALL be 1 exactly in RUN (BW cycles) and 0 in IDLE and DONE.
REQ-019 done SHALL be 1 exactly in DONE.
REQ-020 product SHALL change only on the RUN->DONE edge and SHALL hold its value through IDLE and the next RUN.
REQ-021 start while in RUN or DONE SHALL be ignored: no queuing and no effect on the current operation.
REQ-022 Changes to a or b after the accepting edge SHALL have no effect on the result.
REQ-023 The result SHALL equal a*b exactly, modulo nothing; 2*BW bits always suffice and no overflow flag is produced.
REQ-024 Back-to-back operation: start held high SHALL be accepted on the first IDLE edge following DONE, giving a period of BW+2 cycles.
REQ-025 count SHALL be ceil(log2(BW)) bits wide; there SHALL be no wrap beyond BW-1.

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE, busy=0, done=0, product=0, and M=Q=P=C=count=0.
REQ-027 Reset SHALL take priority over start and over any RUN or DONE activity.
REQ-028 Reset asserted mid-RUN SHALL abort the operation: product stays 0 and no done pulse is produced.
REQ-029 The first start after rst_n returns high SHALL be accepted on the first edge with rst_n=1.

Verification (BW=16)
REQ-030 Basic multiply: a=3, b=5, start for 1 cycle -> busy high for 16 cycles, then done=1 for 1 cycle with product=0x0000000F.
REQ-031 Maximum operands: a=0xFFFF, b=0xFFFF -> product=0xFFFE0001.
REQ-032 Zero and boundary operands: a=0, b=0x1234 -> product=0; then a=0x8000, b=0x0002 -> product=0x00010000.
REQ-033 Ignored start: start pulse with a=7 mid-RUN of a=2, b=9 -> product=0x12, single done pulse, busy timing unchanged.
REQ-034 Reset mid-operation: rst_n=0 at RUN cycle 8 -> next cycle busy=0, done=0, product=0; no done pulse follows.
REQ-035 Back-to-back operation: start held high with a=0x00FF, b=0x0101 -> done pulses every 18 cycles, each with product=0x0000FFFF.
